mp_addsub_seq: RTL

Multi-precision add/subtract sequencer. It reuses one 8-bit add slice over NBYTES cycles to add or subtract two NBYTES-byte operands, least-significant byte first, and chains the carry through a register. It sits between the control/FSM logic and the 8-bit arithmetic datapath, and produces a full-width result plus N/V/Z/C flags matching the 8-bit adder's flag semantics, extended to the whole word.

---
 rtl/mp_addsub_seq_pkg.sv | 20 ++
 rtl/mp_addsub_seq_if.sv | 36 +++
 rtl/mp_addsub_seq_byte_slice.sv | 26 ++
 rtl/mp_addsub_seq.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// Optional carry-in feature is selected with macro MPA_CARRY_IN_EN.
package mp_addsub_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Request/result bundle of the sequencer; master = requester, slave = sequencer.
// With MPA_CARRY_IN_EN defined the bundle carries an extra initial-carry input ci.
interface mp_addsub_seq_if #(
  parameter int unsigned NBYTES = 4
);
  import mp_addsub_seq_pkg::*;

  localparam int unsigned W = BYTE_W * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         c;
  logic         v;
  logic         n;
  logic         z;

`ifdef MPA_CARRY_IN_EN
  logic         ci;

  modport master (output start, sub, a, b, ci,
                  input  busy, done, y, c, v, n, z);
  modport slave  (input  start, sub, a, b, ci,
                  output busy, done, y, c, v, n, z);
`else
  modport master (output start, sub, a, b,
                  input  busy, done, y, c, v, n, z);
  modport slave  (input  start, sub, a, b,
                  output busy, done, y, c, v, n, z);
`endif

endinterface

// File: rtl/mp_addsub_seq_byte_slice.sv
// Combinational 8-bit ripple adder built from full-adder cells; also exposes
// the carry into bit 7 so the caller can form signed overflow.
module mpa_byte_slice
  import mp_addsub_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              ci_i,
  output logic [BYTE_W-1:0] s_o,
  output logic              co_o,
  output logic              c7_o
);

  logic [BYTE_W:0] cy;

  assign cy[0] = ci_i;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign s_o[i]    = a_i[i] ^ b_i[i] ^ cy[i];
    assign cy[i + 1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = cy[BYTE_W];
  assign c7_o = cy[BYTE_W - 1];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract: one byte slice reused over NBYTES cycles, LSB first.
// Define MPA_CARRY_IN_EN to take the initial carry from bus.ci instead of bus.sub.
module mp_addsub_seq
  import mp_addsub_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CW     = $clog2(NBYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  mp_addsub_seq_if.slave   bus
);

  localparam int unsigned   W        = BYTE_W * NBYTES;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  state_e            state_q;
  logic [CW-1:0]     idx_q;
  logic              carry_q;
  logic              sub_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      yw_q;
  logic [W-1:0]      yw_d;
  logic [W-1:0]      y_q;
  flags_t            fl_q;
  flags_t            fl_d;
  flags_t            flo_q;
  logic              busy_q;
  logic              done_q;

  logic [CW+2:0]     bsel;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic              co;
  logic              c7;
  logic              cin;

`ifdef MPA_CARRY_IN_EN
  assign cin = bus.ci;
`else
  assign cin = bus.sub;
`endif

  // Bit offset of the current byte within the operand words.
  assign bsel   = {idx_q, 3'b000};
  assign a_byte = a_q[bsel +: BYTE_W];
  assign b_byte = b_q[bsel +: BYTE_W] ^ {BYTE_W{sub_q}};

  mpa_byte_slice u_slice (
    .a_i  (a_byte),
    .b_i  (b_byte),
    .ci_i (carry_q),
    .s_o  (s_byte),
    .co_o (co),
    .c7_o (c7)
  );

  // Working result with this cycle's byte merged in; z/n need the complete word.
  always_comb begin
    yw_d                    = yw_q;
    yw_d[bsel +: BYTE_W]    = s_byte;
  end

  assign fl_d = '{n: yw_d[W-1], v: c7 ^ co, z: ~|yw_d, c: co};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      yw_q    <= '0;
      y_q     <= '0;
      fl_q    <= '0;
      flo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            carry_q <= cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          yw_q    <= yw_d;
          carry_q <= co;
          if (idx_q == LAST_IDX) begin
            fl_q    <= fl_d;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        ST_DONE: begin
          y_q     <= yw_q;
          flo_q   <= fl_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.c    = flo_q.c;
  assign bus.v    = flo_q.v;
  assign bus.n    = flo_q.n;
  assign bus.z    = flo_q.z;

endmodule
